// File: rtl/ide_arb_pkg.sv
// rtl/ide_arb_pkg.sv - shared types and field positions for the IDE port arbiter
package ide_arb_pkg;

  localparam int MAX_DEV     = 4;
  localparam int REQ_W       = 6;
  localparam int REQ_CMD_BIT = 0;
  localparam int REQ_DRQ_BIT = 1;
  localparam int REQ_ID_LSB  = 4;
  localparam int REQ_ID_MSB  = 5;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANTED = 2'd1,
    ST_RELEASE = 2'd2
  } arb_state_t;

  // Build the word hps_ext sees on ide_req: {grant_id, 2'b00, drq, cmd}.
  function automatic logic [REQ_W-1:0] pack_req(input logic [1:0] id, input logic [1:0] req);
    logic [REQ_W-1:0] v;
    v                         = '0;
    v[REQ_ID_MSB:REQ_ID_LSB]  = id;
    v[REQ_DRQ_BIT]            = req[1];
    v[REQ_CMD_BIT]            = req[0];
    return v;
  endfunction

endpackage

// File: rtl/ide_port_arbiter_rr_pick.sv
// rtl/ide_port_arbiter_rr_pick.sv - combinational round-robin picker for the IDE port arbiter
module rr_pick
  import ide_arb_pkg::*;
#(
  parameter int NUM_DEV = 3
) (
  input  logic [MAX_DEV-1:0] req,
  input  logic [1:0]         ptr,
  output logic [1:0]         idx,
  output logic               valid
);

  // Scan from the farthest candidate back to ptr so the first requester at or after ptr wins.
  always_comb begin
    logic [2:0] c;
    idx   = '0;
    valid = 1'b0;
    c     = '0;
    for (int i = NUM_DEV - 1; i >= 0; i--) begin
      c = {1'b0, ptr} + 3'(i);
      if (c >= 3'(NUM_DEV)) c = c - 3'(NUM_DEV);
      if (req[c[1:0]]) begin
        idx   = c[1:0];
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/ide_port_arbiter.sv
// rtl/ide_port_arbiter.sv - round-robin sharing of the HPS IDE task-file port among IDE devices
module ide_port_arbiter
  import ide_arb_pkg::*;
#(
  parameter int NUM_DEV = 3,
  parameter int REL_DLY = 4,
  parameter int TIMEOUT = 4095
) (
  input  logic                   clk_sys,
  input  logic                   reset_n,
  input  logic                   io_uio,
  input  logic [4:0]             hps_addr,
  input  logic [15:0]            hps_dout,
  input  logic                   hps_rd,
  input  logic                   hps_wr,
  output logic [15:0]            hps_din,
  output logic [5:0]             hps_req,
  input  logic [2*NUM_DEV-1:0]   dev_req,
  input  logic [16*NUM_DEV-1:0]  dev_din,
  output logic [4:0]             dev_addr,
  output logic [15:0]            dev_dout,
  output logic [NUM_DEV-1:0]     dev_rd,
  output logic [NUM_DEV-1:0]     dev_wr,
  output logic                   grant_valid
);

  localparam logic [3:0]  REL_LIM = 4'(REL_DLY);
  localparam logic [11:0] TO_LIM  = 12'(TIMEOUT);

  arb_state_t          state, state_nxt;
  logic [1:0]          grant_id;
  logic [1:0]          rr_ptr;
  logic [3:0]          idle_cnt;
  logic [11:0]         to_cnt;
  logic [1:0]          pick_idx;
  logic                pick_valid;
  logic [1:0]          req_ext [MAX_DEV];
  logic [15:0]         din_ext [MAX_DEV];
  logic [MAX_DEV-1:0]  req_any;
  logic                strobe;
  logic                req_g;
  logic                rel_cond;
  logic                granted;

  // Widen the device buses to MAX_DEV slots; absent slots never request and read as zero.
  for (genvar n = 0; n < MAX_DEV; n++) begin : g_ext
    if (n < NUM_DEV) begin : g_on
      assign req_ext[n] = dev_req[2*n +: 2];
      assign din_ext[n] = dev_din[16*n +: 16];
    end else begin : g_off
      assign req_ext[n] = 2'b00;
      assign din_ext[n] = 16'h0000;
    end
    assign req_any[n] = |req_ext[n];
  end

  rr_pick #(.NUM_DEV(NUM_DEV)) u_pick (
    .req   (req_any),
    .ptr   (rr_ptr),
    .idx   (pick_idx),
    .valid (pick_valid)
  );

  assign granted     = (state == ST_GRANTED);
  assign grant_valid = granted;
  assign strobe      = hps_rd | hps_wr;
  assign req_g       = req_any[grant_id];
  // A strobe in the same cycle as the release condition wins; the release waits.
  assign rel_cond    = !io_uio && !strobe && ((idle_cnt >= REL_LIM) || (to_cnt >= TO_LIM));

  // State register.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nxt;
  end

  // Next-state logic: never take or drop a grant while a UIO transfer is in flight.
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:    if (!io_uio && pick_valid) state_nxt = ST_GRANTED;
      ST_GRANTED: if (rel_cond) state_nxt = ST_RELEASE;
      ST_RELEASE: state_nxt = ST_IDLE;
      default:    state_nxt = ST_IDLE;
    endcase
  end

  // Latch the picked device on grant; advance the round-robin pointer past it on release.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      grant_id <= 2'd0;
      rr_ptr   <= 2'd0;
    end else begin
      if (state == ST_IDLE && state_nxt == ST_GRANTED) grant_id <= pick_idx;
      if (state == ST_RELEASE)
        rr_ptr <= (grant_id == 2'(NUM_DEV - 1)) ? 2'd0 : grant_id + 2'd1;
    end
  end

  // Saturating idle and no-activity counters, live only while a grant is held.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      idle_cnt <= '0;
      to_cnt   <= '0;
    end else if (!granted) begin
      idle_cnt <= '0;
      to_cnt   <= '0;
    end else begin
      if (req_g)                   idle_cnt <= '0;
      else if (idle_cnt != 4'hF)   idle_cnt <= idle_cnt + 4'd1;
      if (strobe)                  to_cnt <= '0;
      else if (req_g && to_cnt != 12'hFFF) to_cnt <= to_cnt + 12'd1;
    end
  end

  // Registered routing of strobes, address, data and request word to/from the granted device.
  always_ff @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      dev_rd   <= '0;
      dev_wr   <= '0;
      dev_addr <= '0;
      dev_dout <= '0;
      hps_din  <= '0;
      hps_req  <= '0;
    end else if (granted) begin
      dev_rd   <= hps_rd ? (NUM_DEV'(1) << grant_id) : '0;
      dev_wr   <= hps_wr ? (NUM_DEV'(1) << grant_id) : '0;
      dev_addr <= hps_addr;
      dev_dout <= hps_dout;
      hps_din  <= din_ext[grant_id];
      hps_req  <= pack_req(grant_id, req_ext[grant_id]);
    end else begin
      dev_rd   <= '0;
      dev_wr   <= '0;
      hps_din  <= '0;
      hps_req  <= '0;
    end
  end

endmodule

// File: tb/tb_ide_port_arbiter.sv
// tb/tb_ide_port_arbiter.sv - self-checking bench for ide_port_arbiter
module tb_ide_port_arbiter;

  localparam int NDEV = 3;
  localparam int REL  = 4;
  localparam int TO   = 16;

  logic        clk_sys = 1'b0;
  logic        reset_n;
  logic        io_uio;
  logic [4:0]  hps_addr;
  logic [15:0] hps_dout;
  logic        hps_rd;
  logic        hps_wr;
  logic [15:0] hps_din;
  logic [5:0]  hps_req;
  logic [5:0]  dev_req;
  logic [47:0] dev_din;
  logic [4:0]  dev_addr;
  logic [15:0] dev_dout;
  logic [2:0]  dev_rd;
  logic [2:0]  dev_wr;
  logic        grant_valid;

  ide_port_arbiter #(.NUM_DEV(NDEV), .REL_DLY(REL), .TIMEOUT(TO)) dut (
    .clk_sys     (clk_sys),
    .reset_n     (reset_n),
    .io_uio      (io_uio),
    .hps_addr    (hps_addr),
    .hps_dout    (hps_dout),
    .hps_rd      (hps_rd),
    .hps_wr      (hps_wr),
    .hps_din     (hps_din),
    .hps_req     (hps_req),
    .dev_req     (dev_req),
    .dev_din     (dev_din),
    .dev_addr    (dev_addr),
    .dev_dout    (dev_dout),
    .dev_rd      (dev_rd),
    .dev_wr      (dev_wr),
    .grant_valid (grant_valid)
  );

  always #5 clk_sys = ~clk_sys;

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: who owns the port, whether we sit in the post-release gap,
  // cycles of quiet (no request) and of stall (request but no strobe).
  int          m_owner = -1;
  bit          m_gap   = 1'b0;
  int          m_quiet = 0;
  int          m_stall = 0;
  int          m_ptr   = 0;
  logic        e_gv    = 1'b0;
  logic [5:0]  e_req   = '0;
  logic [15:0] e_din   = '0;
  logic [2:0]  e_rd    = '0;
  logic [2:0]  e_wr    = '0;
  logic [4:0]  e_addr  = '0;
  logic [15:0] e_dout  = '0;

  task automatic model_step();
    int o, q, s, p, cand;
    bit gap, strobe, found;
    logic [1:0] r;
    o = m_owner; q = m_quiet; s = m_stall; p = m_ptr; gap = m_gap;
    if (o >= 0) begin
      r = dev_req[2*o +: 2];
      e_rd   <= hps_rd ? 3'(1 << o) : 3'b000;
      e_wr   <= hps_wr ? 3'(1 << o) : 3'b000;
      e_addr <= hps_addr;
      e_dout <= hps_dout;
      e_din  <= dev_din[16*o +: 16];
      e_req  <= {2'(o), 2'b00, r};
    end else begin
      e_rd  <= '0;
      e_wr  <= '0;
      e_din <= '0;
      e_req <= '0;
    end
    strobe = hps_rd | hps_wr;
    if (gap) begin
      gap = 1'b0;
    end else if (o < 0) begin
      found = 1'b0;
      if (!io_uio) begin
        for (int k = 0; k < NDEV; k++) begin
          cand = (p + k) % NDEV;
          if (!found && dev_req[2*cand +: 2] != 2'b00) begin
            found = 1'b1;
            o = cand; q = 0; s = 0;
          end
        end
      end
    end else begin
      r = dev_req[2*o +: 2];
      if (!io_uio && !strobe && (q >= REL || s >= TO)) begin
        p = (o + 1) % NDEV;
        o = -1;
        gap = 1'b1;
      end else begin
        q = (r == 2'b00) ? ((q < 15) ? q + 1 : 15) : 0;
        if (strobe) s = 0;
        else if (r != 2'b00 && s < 4095) s = s + 1;
      end
    end
    m_owner <= o; m_quiet <= q; m_stall <= s; m_ptr <= p; m_gap <= gap;
    e_gv <= (o >= 0);
  endtask

  always @(posedge clk_sys or negedge reset_n) begin
    if (!reset_n) begin
      m_owner <= -1; m_gap <= 1'b0; m_quiet <= 0; m_stall <= 0; m_ptr <= 0;
      e_gv <= 1'b0; e_req <= '0; e_din <= '0; e_rd <= '0; e_wr <= '0;
      e_addr <= '0; e_dout <= '0;
    end else begin
      model_step();
    end
  end

  bit chk_en = 1'b0;

  always @(negedge clk_sys) begin
    if (chk_en) begin
      chk("grant_valid", 32'(grant_valid), 32'(e_gv));
      chk("hps_req",     32'(hps_req),     32'(e_req));
      chk("hps_din",     32'(hps_din),     32'(e_din));
      chk("dev_rd",      32'(dev_rd),      32'(e_rd));
      chk("dev_wr",      32'(dev_wr),      32'(e_wr));
      chk("dev_addr",    32'(dev_addr),    32'(e_addr));
      chk("dev_dout",    32'(dev_dout),    32'(e_dout));
    end
  end

  // Grant order recorder: device id taken from hps_req one cycle after grant_valid rises.
  logic [1:0] grants[$];
  bit rec_en = 1'b0;
  bit gv_d = 1'b0;
  bit rise_pending = 1'b0;
  always @(negedge clk_sys) begin
    if (rec_en && rise_pending) grants.push_back(hps_req[5:4]);
    rise_pending <= grant_valid && !gv_d;
    gv_d <= grant_valid;
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk_sys);
      #1;
      dev_din = {16'($urandom), 16'($urandom), 16'($urandom)};
    end
  endtask

  task automatic do_reset();
    reset_n = 1'b0;
    step(2);
    reset_n = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int w, cnt, r, thr, o;
    bit done;
    reset_n = 1'b0; io_uio = 1'b0; hps_addr = '0; hps_dout = '0;
    hps_rd = 1'b0; hps_wr = 1'b0; dev_req = '0; dev_din = '0;
    step(3);
    chk("rst_grant_valid", 32'(grant_valid), 32'd0);
    chk("rst_hps_req",     32'(hps_req),     32'd0);
    chk("rst_dev_rd",      32'(dev_rd),      32'd0);
    chk("rst_hps_din",     32'(hps_din),     32'd0);
    reset_n = 1'b1;
    chk_en = 1'b1;

    // Single requester on device 0.
    dev_req = 6'b000001;
    step(1);
    chk("t1_grant", 32'(grant_valid), 32'd1);
    step(1);
    chk("t1_hps_req", 32'(hps_req), 32'b00_00_01);
    dev_req = '0;
    step(8);
    chk("t1_released", 32'(grant_valid), 32'd0);

    // Write on device 1.
    dev_req = 6'b000100;
    step(1);
    hps_wr = 1'b1; hps_addr = 5'h07; hps_dout = 16'hA5A5;
    step(1);
    hps_wr = 1'b0;
    chk("t3_dev_wr",   32'(dev_wr),   32'b010);
    chk("t3_dev_addr", 32'(dev_addr), 32'h07);
    chk("t3_dev_dout", 32'(dev_dout), 32'hA5A5);
    dev_req = '0;
    step(8);

    // Three requesters, each dropping after three reads; device re-requests after its release.
    do_reset();
    grants.delete();
    rec_en = 1'b1;
    dev_req = 6'b010101;
    for (int g = 0; g < 4; g++) begin
      w = 0;
      while (!grant_valid && w < 20) begin step(1); w++; end
      chk("t2_grant_wait", 32'(grant_valid), 32'd1);
      o = (m_owner < 0) ? 0 : m_owner;
      repeat (3) begin
        hps_rd = 1'b1; step(1);
        hps_rd = 1'b0; step(1);
      end
      dev_req[2*o +: 2] = 2'b00;
      w = 0;
      while (grant_valid && w < 20) begin step(1); w++; end
      chk("t2_release_wait", 32'(grant_valid), 32'd0);
      dev_req[2*o +: 2] = 2'b01;
    end
    dev_req = '0;
    step(10);
    rec_en = 1'b0;
    chk("t2_order_len", 32'(grants.size()), 32'd4);
    if (grants.size() >= 4) begin
      chk("t2_order0", 32'(grants[0]), 32'd0);
      chk("t2_order1", 32'(grants[1]), 32'd1);
      chk("t2_order2", 32'(grants[2]), 32'd2);
      chk("t2_order3", 32'(grants[3]), 32'd0);
    end

    // Timeout: dev0 holds request with no strobes, dev2 waiting.
    do_reset();
    grants.delete();
    rec_en = 1'b1;
    dev_req = 6'b010001;
    cnt = 0; done = 1'b0;
    for (int c = 0; c < 40; c++) begin
      if (!done) begin
        step(1);
        if (grant_valid) cnt++;
        else if (cnt > 0) done = 1'b1;
      end
    end
    chk("t4_timeout_len", 32'(cnt), 32'd17);
    step(4);
    rec_en = 1'b0;
    chk("t4_grants_len", 32'(grants.size() >= 2), 32'd1);
    if (grants.size() >= 2) begin
      chk("t4_first",  32'(grants[0]), 32'd0);
      chk("t4_second", 32'(grants[1]), 32'd2);
    end
    dev_req = '0;
    step(25);

    // Release condition met while io_uio is high.
    do_reset();
    dev_req = 6'b000001;
    step(2);
    dev_req = '0; io_uio = 1'b1;
    step(10);
    chk("t5_held", 32'(grant_valid), 32'd1);
    io_uio = 1'b0;
    step(1);
    chk("t5_release", 32'(grant_valid), 32'd0);
    step(4);

    // Asynchronous reset during a read burst.
    do_reset();
    dev_req = 6'b000001;
    step(2);
    hps_rd = 1'b1;
    step(2);
    chk("t6_rd_active", 32'(dev_rd), 32'b001);
    #2;
    reset_n = 1'b0;
    #1;
    chk("t6_dev_rd",  32'(dev_rd),      32'd0);
    chk("t6_hps_req", 32'(hps_req),     32'd0);
    chk("t6_gv",      32'(grant_valid), 32'd0);
    hps_rd = 1'b0; dev_req = '0;
    step(2);
    reset_n = 1'b1;

    // Randomized traffic against the model.
    for (int n = 0; n < 3000; n++) begin
      io_uio = ($urandom_range(0, 9) < 2);
      for (int d = 0; d < NDEV; d++)
        if ($urandom_range(0, 7) == 0)
          dev_req[2*d +: 2] = ($urandom_range(0, 2) == 0) ? 2'b00 : 2'($urandom_range(1, 3));
      r = $urandom_range(0, 99);
      thr = (((n / 300) % 2) != 0) ? 20 : 2;
      hps_rd = (r < thr);
      hps_wr = (r >= 100 - thr);
      hps_addr = 5'($urandom);
      hps_dout = 16'($urandom);
      step(1);
    end
    hps_rd = 1'b0; hps_wr = 1'b0;
    step(2);
    chk_en = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
